cnn_axi_rd_arbiter: RTL and testbench

//  Shares the single AXI4 read master port of the CNN top between two requesters:

---
 rtl/cnn_axi_rd_arbiter.sv | 172 +++++++++++++++++
 tb/tb_cnn_axi_rd_arbiter.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cnn_axi_rd_arbiter.sv
// Two-requester AXI4 read arbiter: one outstanding burst, round-robin grant, R routed to the granted port.
// Optional: define CNN_ARB_FIXED_PRIO_EN to make port 0 (LCD) win whenever both ports request.
module cnn_axi_rd_arbiter #(
  parameter int unsigned ADDR_WIDTH   = 32,
  parameter int unsigned DATA_WIDTH   = 64,
  parameter int unsigned ID_MAX_WIDTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ADDR_WIDTH-1:0]   req0_addr,
  input  logic [3:0]              req0_len,
  input  logic                    req0_valid,
  output logic                    req0_ready,
  input  logic [ADDR_WIDTH-1:0]   req1_addr,
  input  logic [3:0]              req1_len,
  input  logic                    req1_valid,
  output logic                    req1_ready,
  output logic [DATA_WIDTH-1:0]   rsp0_data,
  output logic                    rsp0_valid,
  output logic                    rsp0_last,
  input  logic                    rsp0_ready,
  output logic [DATA_WIDTH-1:0]   rsp1_data,
  output logic                    rsp1_valid,
  output logic                    rsp1_last,
  input  logic                    rsp1_ready,
  output logic [ADDR_WIDTH-1:0]   araddr,
  output logic [3:0]              arlen,
  output logic [ID_MAX_WIDTH-1:0] arid,
  output logic [2:0]              arsize,
  output logic [1:0]              arbrust,
  output logic                    arvalid,
  input  logic                    arready,
  input  logic [ID_MAX_WIDTH-1:0] rid,
  input  logic [DATA_WIDTH-1:0]   rdata,
  input  logic [1:0]              rresp,
  input  logic                    rlast,
  input  logic                    rvalid,
  output logic                    rready,
  output logic                    o_err
);

  localparam int unsigned LEN_WIDTH = 4;
  localparam int unsigned SIZE_VAL  = $clog2(DATA_WIDTH / 8);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_t;

  state_t                 state, state_nx;
  logic                   grant, grant_nx;
  logic [ADDR_WIDTH-1:0]  araddr_nx;
  logic [LEN_WIDTH-1:0]   arlen_nx;
  logic                   arvalid_nx;
  logic                   req0_ready_nx, req1_ready_nx;
  logic [LEN_WIDTH-1:0]   beat_cnt, beat_cnt_nx;
  logic                   err_nx;
  logic                   any_req;
  logic                   pick;
  logic                   r_hs;
  logic                   beat_err;

  assign any_req = req0_valid || req1_valid;

`ifdef CNN_ARB_FIXED_PRIO_EN
  assign pick = req0_valid ? 1'b0 : 1'b1;
`else
  logic rr_ptr;

  // rr_ptr remembers the last winner; a tie goes to the other port
  assign pick = (req0_valid && req1_valid) ? ~rr_ptr : req1_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= 1'b0;
    end else if (state == IDLE && any_req) begin
      rr_ptr <= pick;
    end
  end
`endif

  assign arsize  = 3'(SIZE_VAL);
  assign arbrust = 2'b01;
  assign arid    = ID_MAX_WIDTH'(grant);

  // R channel is a straight pass-through to the granted requester while in DATA
  assign rready     = (state == DATA) && (grant ? rsp1_ready : rsp0_ready);
  assign rsp0_data  = rdata;
  assign rsp1_data  = rdata;
  assign rsp0_valid = (state == DATA) && !grant && rvalid;
  assign rsp1_valid = (state == DATA) &&  grant && rvalid;
  assign rsp0_last  = (state == DATA) && !grant && rlast;
  assign rsp1_last  = (state == DATA) &&  grant && rlast;

  assign r_hs     = (state == DATA) && rvalid && rready;
  assign beat_err = (rresp != 2'b00) || (rid != arid) ||
                    (rlast && beat_cnt != '0) || (!rlast && beat_cnt == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      grant      <= 1'b0;
      araddr     <= '0;
      arlen      <= '0;
      arvalid    <= 1'b0;
      req0_ready <= 1'b0;
      req1_ready <= 1'b0;
      beat_cnt   <= '0;
      o_err      <= 1'b0;
    end else begin
      state      <= state_nx;
      grant      <= grant_nx;
      araddr     <= araddr_nx;
      arlen      <= arlen_nx;
      arvalid    <= arvalid_nx;
      req0_ready <= req0_ready_nx;
      req1_ready <= req1_ready_nx;
      beat_cnt   <= beat_cnt_nx;
      o_err      <= err_nx;
    end
  end

  always_comb begin
    state_nx      = state;
    grant_nx      = grant;
    araddr_nx     = araddr;
    arlen_nx      = arlen;
    arvalid_nx    = arvalid;
    req0_ready_nx = 1'b0;
    req1_ready_nx = 1'b0;
    beat_cnt_nx   = beat_cnt;
    err_nx        = o_err;

    case (state)
      IDLE: begin
        if (any_req) begin
          grant_nx      = pick;
          araddr_nx     = pick ? req1_addr : req0_addr;
          arlen_nx      = pick ? req1_len  : req0_len;
          arvalid_nx    = 1'b1;
          req0_ready_nx = !pick;
          req1_ready_nx = pick;
          state_nx      = ADDR;
        end
      end
      ADDR: begin
        if (arready) begin
          arvalid_nx  = 1'b0;
          beat_cnt_nx = arlen;
          state_nx    = DATA;
        end
      end
      DATA: begin
        if (r_hs) begin
          beat_cnt_nx = beat_cnt - 4'd1;
          if (beat_err) begin
            err_nx = 1'b1;
          end
          // an exhausted count ends the burst even if the slave never raised rlast
          if (rlast || beat_cnt == '0) begin
            state_nx = IDLE;
          end
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_cnn_axi_rd_arbiter.sv
// Scoreboard bench for cnn_axi_rd_arbiter: directed bursts, a scripted AXI slave, and
// negedge monitors that pop expected AR payloads and R beats from queues.
module tb_cnn_axi_rd_arbiter;

  logic        clk;
  logic        rst;
  logic [31:0] req0_addr, req1_addr;
  logic [3:0]  req0_len, req1_len;
  logic        req0_valid, req1_valid, req0_ready, req1_ready;
  logic [63:0] rsp0_data, rsp1_data;
  logic        rsp0_valid, rsp0_last, rsp0_ready;
  logic        rsp1_valid, rsp1_last, rsp1_ready;
  logic [31:0] araddr;
  logic [3:0]  arlen, arid, rid;
  logic [2:0]  arsize;
  logic [1:0]  arbrust, rresp;
  logic        arvalid, arready;
  logic [63:0] rdata;
  logic        rlast, rvalid, rready, o_err;

  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  len;
    logic [3:0]  id;
  } ar_t;

  typedef struct packed {
    logic [63:0] data;
    logic        last;
  } beat_t;

  ar_t   exp_ar[$];
  beat_t q0[$];
  beat_t q1[$];

  int n_vec = 0;
  int n_err = 0;
  int n_iss = 0;
  int n_rdy = 0;
  logic tog1 = 1'b0;

  cnn_axi_rd_arbiter dut (
    .clk(clk), .rst(rst),
    .req0_addr(req0_addr), .req0_len(req0_len), .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req1_addr(req1_addr), .req1_len(req1_len), .req1_valid(req1_valid), .req1_ready(req1_ready),
    .rsp0_data(rsp0_data), .rsp0_valid(rsp0_valid), .rsp0_last(rsp0_last), .rsp0_ready(rsp0_ready),
    .rsp1_data(rsp1_data), .rsp1_valid(rsp1_valid), .rsp1_last(rsp1_last), .rsp1_ready(rsp1_ready),
    .araddr(araddr), .arlen(arlen), .arid(arid), .arsize(arsize), .arbrust(arbrust),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .o_err(o_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no $finish, expected run to complete");
    $fatal(1, "simulation timeout");
  end

  // Requester 1 either always accepts or alternates its ready every cycle
  initial begin
    rsp1_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      rsp1_ready = tog1 ? !rsp1_ready : 1'b1;
    end
  end

  function automatic void chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  function automatic void fail_now(input string nm);
    n_vec++;
    n_err++;
    $display("FAIL %s: got unexpected/missing event, expected none", nm);
  endfunction

  // Monitors: AR handshakes, R beats per port, ready pulses, rready mirroring
  always @(negedge clk) begin
    ar_t   e;
    beat_t b;
    if (arvalid && arready) begin
      if (exp_ar.size() == 0) fail_now("ar_unexpected");
      else begin
        e = exp_ar.pop_front();
        chk("ar_payload", 128'({araddr, arlen, arid}), 128'(e));
        chk("ar_size_burst", 128'({arsize, arbrust}), 128'({3'd3, 2'b01}));
      end
    end
    if (rsp0_valid) begin
      chk("rready_mirror0", 128'(rready), 128'(rsp0_ready));
      chk("rsp1_idle", 128'(rsp1_valid), 128'(0));
      if (rsp0_ready) begin
        if (q0.size() == 0) fail_now("rsp0_unexpected");
        else begin
          b = q0.pop_front();
          chk("rsp0_beat", 128'({rsp0_data, rsp0_last}), 128'(b));
        end
      end
    end
    if (rsp1_valid) begin
      chk("rready_mirror1", 128'(rready), 128'(rsp1_ready));
      if (rsp1_ready) begin
        if (q1.size() == 0) fail_now("rsp1_unexpected");
        else begin
          b = q1.pop_front();
          chk("rsp1_beat", 128'({rsp1_data, rsp1_last}), 128'(b));
        end
      end
    end
    if (req0_ready) n_rdy++;
    if (req1_ready) n_rdy++;
  end

  task automatic issue(input int p, input logic [31:0] a, input logic [3:0] l,
                       input int nb, input logic lastf);
    beat_t b;
    logic  got;
    for (int i = 0; i < nb; i++) begin
      b.data = {a, 32'(i)};
      b.last = lastf && (i == nb - 1);
      if (p == 0) q0.push_back(b);
      else        q1.push_back(b);
    end
    n_iss++;
    if (p == 0) begin req0_addr = a; req0_len = l; req0_valid = 1'b1; end
    else        begin req1_addr = a; req1_len = l; req1_valid = 1'b1; end
    got = 1'b0;
    for (int c = 0; c < 1000 && !got; c++) begin
      @(negedge clk);
      got = (p == 0) ? req0_ready : req1_ready;
    end
    if (!got) fail_now("req_ready_timeout");
    @(posedge clk);
    #1;
    if (p == 0) req0_valid = 1'b0;
    else        req1_valid = 1'b0;
  endtask

  task automatic ar_accept(input int dly, output logic [31:0] a, output logic [3:0] l,
                           output logic [3:0] id);
    logic got = 1'b0;
    for (int c = 0; c < 1000 && !got; c++) begin
      @(negedge clk);
      got = arvalid;
    end
    if (!got) fail_now("arvalid_timeout");
    a  = araddr;
    l  = arlen;
    id = arid;
    for (int d = 0; d < dly; d++) begin
      chk("ar_hold_valid", 128'(arvalid), 128'(1));
      chk("ar_hold_payload", 128'({araddr, arlen}), 128'({a, l}));
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    arready = 1'b1;
    @(posedge clk);
    #1;
    arready = 1'b0;
  endtask

  task automatic send_beat(input logic [31:0] a, input logic [3:0] id, input int i, input logic last);
    logic hs = 1'b0;
    rvalid = 1'b1;
    rid    = id;
    rdata  = {a, 32'(i)};
    rlast  = last;
    for (int c = 0; c < 1000 && !hs; c++) begin
      @(negedge clk);
      hs = rready;
      @(posedge clk);
      #1;
    end
    if (!hs) fail_now("rready_timeout");
    rvalid = 1'b0;
    rlast  = 1'b0;
  endtask

  // early >= 0 makes the slave raise rlast on beat index 'early'
  task automatic serve(input int dly, input int early);
    logic [31:0] a;
    logic [3:0]  l, id;
    int          n;
    ar_accept(dly, a, l, id);
    n = (early >= 0) ? early + 1 : int'(l) + 1;
    for (int i = 0; i < n; i++) send_beat(a, id, i, i == n - 1);
  endtask

  task automatic dual(input int nb, input logic [31:0] b0, input logic [31:0] b1);
    ar_t e0, e1;
`ifdef CNN_ARB_FIXED_PRIO_EN
    for (int k = 0; k < nb; k++) begin
      e0 = '{addr: b0 + 32'(k * 256), len: 4'd1, id: 4'd0};
      exp_ar.push_back(e0);
    end
    for (int k = 0; k < nb; k++) begin
      e1 = '{addr: b1 + 32'(k * 256), len: 4'd2, id: 4'd1};
      exp_ar.push_back(e1);
    end
`else
    // last winner before each call is port 0, so port 1 takes the first tie
    for (int k = 0; k < nb; k++) begin
      e1 = '{addr: b1 + 32'(k * 256), len: 4'd2, id: 4'd1};
      e0 = '{addr: b0 + 32'(k * 256), len: 4'd1, id: 4'd0};
      exp_ar.push_back(e1);
      exp_ar.push_back(e0);
    end
`endif
    fork
      for (int k = 0; k < nb; k++) issue(0, b0 + 32'(k * 256), 4'd1, 2, 1'b1);
      for (int k = 0; k < nb; k++) issue(1, b1 + 32'(k * 256), 4'd2, 3, 1'b1);
      for (int k = 0; k < 2 * nb; k++) serve(0, -1);
    join
  endtask

  initial begin
    logic [31:0] a;
    logic [3:0]  l, id;
    rst = 1'b1;
    req0_addr = '0; req0_len = '0; req0_valid = 1'b0;
    req1_addr = '0; req1_len = '0; req1_valid = 1'b0;
    rsp0_ready = 1'b1;
    arready = 1'b0;
    rid = '0; rdata = '0; rresp = 2'b00; rlast = 1'b0; rvalid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_arvalid", 128'(arvalid), 128'(0));
    chk("rst_rready", 128'(rready), 128'(0));
    chk("rst_req_ready", 128'({req0_ready, req1_ready}), 128'(0));
    chk("rst_rsp_valid", 128'({rsp0_valid, rsp1_valid}), 128'(0));
    chk("rst_err", 128'(o_err), 128'(0));
    chk("rst_size_burst", 128'({arsize, arbrust}), 128'({3'd3, 2'b01}));
    @(posedge clk);
    #1;
    rst = 1'b0;

    // T1: single burst on port 0
    exp_ar.push_back('{addr: 32'h1000, len: 4'd3, id: 4'd0});
    fork
      issue(0, 32'h1000, 4'd3, 4, 1'b1);
      serve(0, -1);
    join

    // T2: both ports contend for four bursts each
    dual(4, 32'h2000, 32'h3000);

    // T3: AR stalled for 10 cycles
    exp_ar.push_back('{addr: 32'h4000, len: 4'd5, id: 4'd0});
    fork
      issue(0, 32'h4000, 4'd5, 6, 1'b1);
      serve(10, -1);
    join

    // T4: port 1 throttles with alternating ready over an 8-beat burst
    tog1 = 1'b1;
    exp_ar.push_back('{addr: 32'h5000, len: 4'd7, id: 4'd1});
    fork
      issue(1, 32'h5000, 4'd7, 8, 1'b1);
      serve(0, -1);
    join
    tog1 = 1'b0;
    @(negedge clk);
    chk("err_clean", 128'(o_err), 128'(0));

    // T5: slave ends a len=3 burst after two beats
    exp_ar.push_back('{addr: 32'h6000, len: 4'd3, id: 4'd0});
    fork
      issue(0, 32'h6000, 4'd3, 2, 1'b1);
      serve(0, 1);
    join
    @(negedge clk);
    chk("early_last_err", 128'(o_err), 128'(1));
    chk("early_last_idle", 128'({arvalid, rready}), 128'(0));
    exp_ar.push_back('{addr: 32'h7000, len: 4'd1, id: 4'd1});
    fork
      issue(1, 32'h7000, 4'd1, 2, 1'b1);
      serve(0, -1);
    join
    chk("err_sticky", 128'(o_err), 128'(1));

    // T6: reset while beat 2 of a burst is on the bus
    exp_ar.push_back('{addr: 32'h8000, len: 4'd3, id: 4'd0});
    fork
      issue(0, 32'h8000, 4'd3, 2, 1'b0);
      begin
        ar_accept(0, a, l, id);
        send_beat(a, id, 0, 1'b0);
        rvalid = 1'b1;
        rid    = id;
        rdata  = {a, 32'd1};
        rlast  = 1'b0;
        rst    = 1'b1;
        @(posedge clk);
        #1;
        rvalid = 1'b0;
        @(negedge clk);
        chk("mid_rst_arvalid", 128'(arvalid), 128'(0));
        chk("mid_rst_rready", 128'(rready), 128'(0));
        chk("mid_rst_rsp_valid", 128'({rsp0_valid, rsp1_valid}), 128'(0));
        chk("mid_rst_err", 128'(o_err), 128'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
      end
    join

    // T7: arbitration after reset
    dual(1, 32'h9000, 32'hA000);

    repeat (5) @(negedge clk);
    chk("ar_queue_drained", 128'(exp_ar.size()), 128'(0));
    chk("rsp0_queue_drained", 128'(q0.size()), 128'(0));
    chk("rsp1_queue_drained", 128'(q1.size()), 128'(0));
    chk("ready_pulse_count", 128'(n_rdy), 128'(n_iss));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
